// File: rtl/car_traffic_controller_if.sv
// rtl/car_traffic_controller_if.sv - car traffic controller control/position bundle
interface car_traffic_controller_if;
    logic       i_Enable;
    logic [1:0] i_Level;
    logic [9:0] i_Frog_X;
    logic [9:0] i_Frog_Y;
    logic [9:0] o_Car_1X;
    logic [9:0] o_Car_2X;
    logic [9:0] o_Car_3X;
    logic [9:0] o_Car_4X;
    logic [8:0] o_Car_1Y;
    logic [8:0] o_Car_2Y;
    logic [8:0] o_Car_3Y;
    logic [8:0] o_Car_4Y;
    logic       o_Frame_Tick;
    logic       o_Collision;
    logic       o_Hit_Pulse;

    modport master (
        output i_Enable, i_Level, i_Frog_X, i_Frog_Y,
        input  o_Car_1X, o_Car_2X, o_Car_3X, o_Car_4X,
        input  o_Car_1Y, o_Car_2Y, o_Car_3Y, o_Car_4Y,
        input  o_Frame_Tick, o_Collision, o_Hit_Pulse
    );

    modport slave (
        input  i_Enable, i_Level, i_Frog_X, i_Frog_Y,
        output o_Car_1X, o_Car_2X, o_Car_3X, o_Car_4X,
        output o_Car_1Y, o_Car_2Y, o_Car_3Y, o_Car_4Y,
        output o_Frame_Tick, o_Collision, o_Hit_Pulse
    );
endinterface

// File: rtl/car_traffic_controller.sv
// rtl/car_traffic_controller.sv - per-frame car sprite movement with optional frog hit freeze
// Optional collision/HIT logic is compiled in with CAR_COLLISION_DETECT_EN.
module car_traffic_controller #(
    parameter int TILE_SIZE      = 32,
    parameter int H_VISIBLE_AREA = 640,
    parameter int FRAME_TICKS    = 420000,
    parameter int LANE_Y_1       = 96,
    parameter int LANE_Y_2       = 160,
    parameter int LANE_Y_3       = 224,
    parameter int LANE_Y_4       = 288,
    parameter int HIT_FRAMES     = 60
) (
    input  logic                           i_Clk,
    input  logic                           i_Reset,
    car_traffic_controller_if.slave        bus
);
    localparam logic [18:0] LAST_TICK = 19'(FRAME_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN
`ifdef CAR_COLLISION_DETECT_EN
        , HIT
`endif
    } state_t;

    state_t      state;
    logic [18:0] count;
    logic [9:0]  x [4];
    logic        frame_tick;
    logic        frame_edge;
    logic [2:0]  slow_step;
    logic [2:0]  fast_step;

    assign frame_edge = (count == LAST_TICK);
    assign slow_step  = {1'b0, bus.i_Level} + 3'd1;
    assign fast_step  = {1'b0, bus.i_Level} + 3'd2;

    function automatic logic [9:0] move_right(input logic [9:0] pos, input logic [2:0] step);
        logic [10:0] sum;
        sum = {1'b0, pos} + {8'b0, step};
        if (sum >= 11'(H_VISIBLE_AREA))
            return 10'(sum - 11'(H_VISIBLE_AREA));
        return sum[9:0];
    endfunction

    function automatic logic [9:0] move_left(input logic [9:0] pos, input logic [2:0] step);
        logic [10:0] wide;
        wide = {1'b0, pos};
        if (wide < {8'b0, step})
            return 10'(wide + 11'(H_VISIBLE_AREA) - {8'b0, step});
        return 10'(wide - {8'b0, step});
    endfunction

`ifdef CAR_COLLISION_DETECT_EN
    localparam int HW = $clog2(HIT_FRAMES + 1);
    localparam logic [HW-1:0] HIT_LAST = HW'(HIT_FRAMES - 1);

    logic [HW-1:0] hit_cnt;
    logic          collision;
    logic          hit_pulse;
    logic          overlap;
    logic [3:0]    car_hit;
    logic [10:0]   frog_x;
    logic [10:0]   frog_y;
    logic [10:0]   lane_y [4];

    assign frog_x    = {1'b0, bus.i_Frog_X};
    assign frog_y    = {1'b0, bus.i_Frog_Y};
    assign lane_y[0] = 11'(LANE_Y_1);
    assign lane_y[1] = 11'(LANE_Y_2);
    assign lane_y[2] = 11'(LANE_Y_3);
    assign lane_y[3] = 11'(LANE_Y_4);

    // Plain 11-bit box test: a car straddling the wrap seam is not considered touching.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            car_hit[n] = (frog_x < {1'b0, x[n]} + 11'(TILE_SIZE)) &&
                         ({1'b0, x[n]} < frog_x + 11'(TILE_SIZE)) &&
                         (frog_y < lane_y[n] + 11'(TILE_SIZE)) &&
                         (lane_y[n] < frog_y + 11'(TILE_SIZE));
        end
    end
    assign overlap = |car_hit;

    assign bus.o_Collision = collision;
    assign bus.o_Hit_Pulse = hit_pulse;
`else
    logic unused_frog;
    assign unused_frog     = ^{bus.i_Frog_X, bus.i_Frog_Y};
    assign bus.o_Collision = 1'b0;
    assign bus.o_Hit_Pulse = 1'b0;
`endif

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state      <= IDLE;
            count      <= '0;
            frame_tick <= 1'b0;
            x[0]       <= 10'd0;
            x[1]       <= 10'd608;
            x[2]       <= 10'd320;
            x[3]       <= 10'd160;
`ifdef CAR_COLLISION_DETECT_EN
            hit_cnt    <= '0;
            collision  <= 1'b0;
            hit_pulse  <= 1'b0;
`endif
        end else begin
            count      <= frame_edge ? '0 : count + 19'd1;
            frame_tick <= frame_edge;
`ifdef CAR_COLLISION_DETECT_EN
            hit_pulse  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.i_Enable)
                        state <= RUN;
                end
                RUN: begin
                    if (!bus.i_Enable) begin
                        state <= IDLE;
`ifdef CAR_COLLISION_DETECT_EN
                    end else if (overlap) begin
                        // Hit beats a coincident frame edge: positions stay put.
                        state     <= HIT;
                        hit_cnt   <= '0;
                        collision <= 1'b1;
                        hit_pulse <= 1'b1;
`endif
                    end else if (frame_edge) begin
                        x[0] <= move_right(x[0], slow_step);
                        x[1] <= move_left(x[1], slow_step);
                        x[2] <= move_right(x[2], fast_step);
                        x[3] <= move_left(x[3], fast_step);
                    end
                end
`ifdef CAR_COLLISION_DETECT_EN
                HIT: begin
                    if (!bus.i_Enable) begin
                        state     <= IDLE;
                        collision <= 1'b0;
                    end else if (frame_edge) begin
                        if (hit_cnt == HIT_LAST) begin
                            state     <= RUN;
                            collision <= 1'b0;
                        end else begin
                            hit_cnt <= hit_cnt + 1'b1;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_Car_1X     = x[0];
    assign bus.o_Car_2X     = x[1];
    assign bus.o_Car_3X     = x[2];
    assign bus.o_Car_4X     = x[3];
    assign bus.o_Car_1Y     = 9'(LANE_Y_1);
    assign bus.o_Car_2Y     = 9'(LANE_Y_2);
    assign bus.o_Car_3Y     = 9'(LANE_Y_3);
    assign bus.o_Car_4Y     = 9'(LANE_Y_4);
    assign bus.o_Frame_Tick = frame_tick;
endmodule

// File: tb/tb_car_traffic_controller.sv
// tb/tb_car_traffic_controller.sv - directed self-checking bench for car_traffic_controller
module tb_car_traffic_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    car_traffic_controller_if bus();

    car_traffic_controller #(
        .TILE_SIZE(32), .H_VISIBLE_AREA(640), .FRAME_TICKS(8),
        .LANE_Y_1(96), .LANE_Y_2(160), .LANE_Y_3(224), .LANE_Y_4(288),
        .HIT_FRAMES(2)
    ) dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] xs();
        return {bus.o_Car_1X, bus.o_Car_2X, bus.o_Car_3X, bus.o_Car_4X};
    endfunction

    task automatic wait_tick();
        int n = 0;
        @(negedge clk);
        while (!bus.o_Frame_Tick && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.o_Frame_Tick) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: no o_Frame_Tick within 20 cycles");
        end
    endtask

    task automatic test_reset();
        bus.i_Enable = 1'b1;
        bus.i_Level  = 2'd0;
        bus.i_Frog_X = 10'd0;
        bus.i_Frog_Y = 10'd0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (xs() !== {10'd0, 10'd608, 10'd320, 10'd160}) begin
            errors++;
            $display("FAIL reset_x: got %h want %h", xs(), {10'd0, 10'd608, 10'd320, 10'd160});
        end
        checks++;
        if ({bus.o_Car_1Y, bus.o_Car_2Y, bus.o_Car_3Y, bus.o_Car_4Y} !== {9'd96, 9'd160, 9'd224, 9'd288}) begin
            errors++;
            $display("FAIL reset_y: got %0d %0d %0d %0d want 96 160 224 288",
                     bus.o_Car_1Y, bus.o_Car_2Y, bus.o_Car_3Y, bus.o_Car_4Y);
        end
        checks++;
        if ({bus.o_Frame_Tick, bus.o_Collision, bus.o_Hit_Pulse} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000",
                     {bus.o_Frame_Tick, bus.o_Collision, bus.o_Hit_Pulse});
        end
    endtask

    task automatic test_first_frame();
        int bad_tick = 0;
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.o_Frame_Tick !== (i == 8)) bad_tick++;
        end
        checks++;
        if (bad_tick != 0) begin
            errors++;
            $display("FAIL first_tick_timing: %0d wrong cycles want 0", bad_tick);
        end
        checks++;
        if (xs() !== {10'd1, 10'd607, 10'd322, 10'd158}) begin
            errors++;
            $display("FAIL first_frame_x: got %h want %h", xs(), {10'd1, 10'd607, 10'd322, 10'd158});
        end
        @(negedge clk);
        checks++;
        if (bus.o_Frame_Tick !== 1'b0) begin
            errors++;
            $display("FAIL tick_width: got %b want 0", bus.o_Frame_Tick);
        end
    endtask

    task automatic test_wrap();
        repeat (606) wait_tick();
        checks++;
        if (xs() !== {10'd607, 10'd1, 10'd254, 10'd226}) begin
            errors++;
            $display("FAIL wrap_pre: got %h want %h", xs(), {10'd607, 10'd1, 10'd254, 10'd226});
        end
        bus.i_Level = 2'd1;
        wait_tick();
        checks++;
        if (xs() !== {10'd609, 10'd639, 10'd257, 10'd223}) begin
            errors++;
            $display("FAIL wrap_left_x2: got %h want %h", xs(), {10'd609, 10'd639, 10'd257, 10'd223});
        end
        bus.i_Level = 2'd0;
        repeat (29) wait_tick();
        checks++;
        if (xs() !== {10'd638, 10'd610, 10'd315, 10'd165}) begin
            errors++;
            $display("FAIL wrap_pre2: got %h want %h", xs(), {10'd638, 10'd610, 10'd315, 10'd165});
        end
        bus.i_Level = 2'd1;
        wait_tick();
        checks++;
        if (xs() !== {10'd0, 10'd608, 10'd318, 10'd162}) begin
            errors++;
            $display("FAIL wrap_right_x1: got %h want %h", xs(), {10'd0, 10'd608, 10'd318, 10'd162});
        end
        bus.i_Level = 2'd3;
        wait_tick();
        checks++;
        if (xs() !== {10'd4, 10'd604, 10'd323, 10'd157}) begin
            errors++;
            $display("FAIL level3_step: got %h want %h", xs(), {10'd4, 10'd604, 10'd323, 10'd157});
        end
    endtask

    task automatic test_hold();
        bus.i_Enable = 1'b0;
        bus.i_Level  = 2'd0;
        for (int f = 0; f < 3; f++) begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.o_Frame_Tick && n < 20);
            checks++;
            if (n != 8) begin
                errors++;
                $display("FAIL hold_tick_period: got %0d cycles want 8", n);
            end
            checks++;
            if (xs() !== {10'd4, 10'd604, 10'd323, 10'd157}) begin
                errors++;
                $display("FAIL hold_x: got %h want %h", xs(), {10'd4, 10'd604, 10'd323, 10'd157});
            end
        end
        bus.i_Enable = 1'b1;
    endtask

`ifdef CAR_COLLISION_DETECT_EN
    task automatic test_collision();
        repeat (2) @(negedge clk);
        bus.i_Frog_X = 10'd20;
        bus.i_Frog_Y = 10'd96;
        @(negedge clk);
        checks++;
        if ({bus.o_Hit_Pulse, bus.o_Collision} !== 2'b11) begin
            errors++;
            $display("FAIL hit_entry: got hit=%b coll=%b want 1 1", bus.o_Hit_Pulse, bus.o_Collision);
        end
        bus.i_Frog_X = 10'd0;
        bus.i_Frog_Y = 10'd0;
        @(negedge clk);
        checks++;
        if ({bus.o_Hit_Pulse, bus.o_Collision} !== 2'b01) begin
            errors++;
            $display("FAIL hit_pulse_width: got hit=%b coll=%b want 0 1", bus.o_Hit_Pulse, bus.o_Collision);
        end
        wait_tick();
        checks++;
        if ({bus.o_Collision, xs()} !== {1'b1, 10'd4, 10'd604, 10'd323, 10'd157}) begin
            errors++;
            $display("FAIL hit_hold1: got coll=%b x=%h want 1 %h", bus.o_Collision, xs(),
                     {10'd4, 10'd604, 10'd323, 10'd157});
        end
        wait_tick();
        checks++;
        if ({bus.o_Collision, xs()} !== {1'b0, 10'd4, 10'd604, 10'd323, 10'd157}) begin
            errors++;
            $display("FAIL hit_exit: got coll=%b x=%h want 0 %h", bus.o_Collision, xs(),
                     {10'd4, 10'd604, 10'd323, 10'd157});
        end
        wait_tick();
        checks++;
        if (xs() !== {10'd5, 10'd603, 10'd325, 10'd155}) begin
            errors++;
            $display("FAIL run_resume: got %h want %h", xs(), {10'd5, 10'd603, 10'd325, 10'd155});
        end
    endtask

    task automatic test_edge_overlap();
        repeat (7) @(negedge clk);
        bus.i_Frog_X = 10'd21;
        bus.i_Frog_Y = 10'd96;
        @(negedge clk);
        checks++;
        if ({bus.o_Frame_Tick, bus.o_Hit_Pulse, bus.o_Collision} !== 3'b111) begin
            errors++;
            $display("FAIL edge_hit_flags: got %b want 111",
                     {bus.o_Frame_Tick, bus.o_Hit_Pulse, bus.o_Collision});
        end
        checks++;
        if (xs() !== {10'd5, 10'd603, 10'd325, 10'd155}) begin
            errors++;
            $display("FAIL edge_hit_no_move: got %h want %h", xs(), {10'd5, 10'd603, 10'd325, 10'd155});
        end
        bus.i_Frog_X = 10'd0;
        bus.i_Frog_Y = 10'd0;
    endtask
`else
    task automatic test_no_collision();
        int seen = 0;
        int n = 0;
        repeat (2) @(negedge clk);
        bus.i_Frog_X = 10'd20;
        bus.i_Frog_Y = 10'd96;
        do begin
            @(negedge clk);
            n++;
            if (bus.o_Collision !== 1'b0 || bus.o_Hit_Pulse !== 1'b0) seen++;
        end while (!bus.o_Frame_Tick && n < 20);
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL no_collision_flags: %0d cycles with flags set want 0", seen);
        end
        checks++;
        if (xs() !== {10'd5, 10'd603, 10'd325, 10'd155}) begin
            errors++;
            $display("FAIL move_under_frog: got %h want %h", xs(), {10'd5, 10'd603, 10'd325, 10'd155});
        end
        repeat (3) @(negedge clk);
    endtask
`endif

    task automatic test_async_reset();
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.o_Collision, bus.o_Hit_Pulse, bus.o_Frame_Tick} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset_flags: got %b want 000",
                     {bus.o_Collision, bus.o_Hit_Pulse, bus.o_Frame_Tick});
        end
        checks++;
        if (xs() !== {10'd0, 10'd608, 10'd320, 10'd160}) begin
            errors++;
            $display("FAIL async_reset_x: got %h want %h", xs(), {10'd0, 10'd608, 10'd320, 10'd160});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_wrap();
        test_hold();
`ifdef CAR_COLLISION_DETECT_EN
        test_collision();
        test_edge_overlap();
`else
        test_no_collision();
`endif
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/car_traffic_controller.md
# car_traffic_controller

Generates the four car sprite positions consumed by the VGA sprite display stage. Each frame it advances the cars horizontally in fixed lanes, wrapping at the screen edges. It optionally detects frog/car overlap and freezes traffic for a penalty period. It sits directly upstream of the display: its `o_Car_nX`/`o_Car_nY` outputs drive the display's car position inputs.

## Interface
- `TILE_SIZE`, 32: sprite edge in pixels; used for overlap.
- `H_VISIBLE_AREA`, 640: horizontal wrap modulus.
- `FRAME_TICKS`, 420000: clocks per frame (800×525); counter is 19 bits.
- `LANE_Y_1`..`LANE_Y_4`, 96/160/224/288: fixed Y of cars 1–4.
- `HIT_FRAMES`, 60: frames spent in HIT.
- `i_Clk` input 1: pixel clock. Single clock domain.
- `i_Reset` input 1: asynchronous, active-high reset.
- `i_Enable` input 1: game running.
- `i_Level` input 2: speed level 0–3.
- `i_Frog_X` input 10: frog left X.
- `i_Frog_Y` input 10: frog top Y.
- `o_Car_1X`..`o_Car_4X` output 10: car X positions.
- `o_Car_1Y`..`o_Car_4Y` output 9: car Y positions, constant `LANE_Y_n`.
- `o_Frame_Tick` output 1: one-cycle pulse, high in the first cycle new positions are valid.
- `o_Collision` output 1: high while in HIT.
- `o_Hit_Pulse` output 1: one-cycle pulse on entry to HIT.

## Operation
- Frame counter runs 0..`FRAME_TICKS`-1 and wraps. It runs in every state and is 0 after reset, which aligns it with the display scan counters.
- A frame edge is the clock edge where counter == `FRAME_TICKS`-1.
- **States:** IDLE (reset state), RUN, HIT.
  - IDLE → RUN: `i_Enable`=1, next edge.
  - RUN → IDLE: `i_Enable`=0.
  - RUN → HIT: overlap detected.
  - HIT → RUN: after `HIT_FRAMES` frame edges, if `i_Enable`=1.
  - HIT → IDLE: `i_Enable`=0, on any edge.
- **Movement:** occurs only in RUN, on a frame edge.
  - Cars 1 and 3 move right; cars 2 and 4 move left.
  - Step is `i_Level`+1 for cars 1–2 and `i_Level`+2 for cars 3–4.
  - `i_Level` is sampled at the frame edge.
- **Wrap, right-moving:** if X+step ≥ `H_VISIBLE_AREA`, new X = X+step−`H_VISIBLE_AREA`; else X+step. Use 11-bit intermediate arithmetic.
- **Wrap, left-moving:** if X < step, new X = X+`H_VISIBLE_AREA`−step; else X−step.
- X always stays in 0..`H_VISIBLE_AREA`-1.
- **Overlap rule** for car n, evaluated every RUN cycle with 11-bit compares and no wrap-around overlap:
  - `i_Frog_X` < Xn+`TILE_SIZE`, and
  - Xn < `i_Frog_X`+`TILE_SIZE`, and
  - `i_Frog_Y` < `LANE_Y_n`+`TILE_SIZE`, and
  - `LANE_Y_n` < `i_Frog_Y`+`TILE_SIZE`.
- **Simultaneous overlap and frame edge in RUN:** HIT wins. The position update on that edge is suppressed.
- In IDLE and HIT, positions hold.
- HIT frame count resets on each HIT entry.

## Timing
- **Reset values:** X1=0, X2=608, X3=320, X4=160; Y outputs = lane parameters; `o_Frame_Tick`=0, `o_Collision`=0, `o_Hit_Pulse`=0; state IDLE; counter 0.
- All outputs are registered.
- Positions update on the frame edge. `o_Frame_Tick` is high for exactly the following cycle, and it pulses every frame regardless of state.
- `o_Collision` and `o_Hit_Pulse` rise one cycle after the overlap-detecting edge.
- `o_Collision` falls in the cycle after leaving HIT.
- Reset mid-frame or mid-HIT returns all registers to reset values immediately (asynchronous reset).

## Configuration
- Macro: `CAR_COLLISION_DETECT_EN`.
- **Defined:** overlap logic, the HIT state, and the HIT frame counter are compiled in, as described above.
- **Undefined:** no HIT state and no overlap logic; `o_Collision` and `o_Hit_Pulse` are tied 0. Movement continues regardless of frog position, and `i_Frog_X`/`i_Frog_Y` are unused.

## Test plan
- Reset with `FRAME_TICKS`=8, `i_Enable`=1, `i_Level`=0 → after the first frame edge, X1=1, X2=607, X3=322, X4=158, with `o_Frame_Tick` high one cycle.
- X1=638, `i_Level`=1 (step 2), RUN → next X1=0. X2=1, step 2 → next X2=639.
- `i_Enable`=0 during RUN → positions hold across ≥3 frame edges; `o_Frame_Tick` still pulses every 8 cycles.
- With the macro defined, frog at (X1+16, `LANE_Y_1`) → `o_Hit_Pulse` one cycle and `o_Collision` high. Positions hold for `HIT_FRAMES`=2 frame edges, then RUN resumes and `o_Collision`=0.
- Overlap on the same edge as a frame edge → HIT is entered and no car moves.
- Assert `i_Reset` mid-HIT → `o_Collision`=0, positions return to 0/608/320/160 without waiting for a clock edge.
